// File: rtl/adder10_4.sv
// Registered 4-digit packed-BCD adder with decimal carry-in/carry-out.
// Latency: 1 clk from operand sampling to registered sum/carry.
// No backpressure: accepts new operands and produces a result every cycle.
module adder10_4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A1,
    input  logic [3:0] A2,
    input  logic [3:0] A3,
    input  logic [3:0] A4,
    input  logic [3:0] B1,
    input  logic [3:0] B2,
    input  logic [3:0] B3,
    input  logic [3:0] B4,
    input  logic       cin,
    output logic [3:0] s1,
    output logic [3:0] s2,
    output logic [3:0] s3,
    output logic [3:0] s4,
    output logic       co
);

    logic [3:0] a_dig [4];
    logic [3:0] b_dig [4];
    logic [3:0] s_dig [4];
    logic [4:0] carry;

    assign a_dig[0] = A1;
    assign a_dig[1] = A2;
    assign a_dig[2] = A3;
    assign a_dig[3] = A4;
    assign b_dig[0] = B1;
    assign b_dig[1] = B2;
    assign b_dig[2] = B3;
    assign b_dig[3] = B4;
    assign carry[0] = cin;

    // Non-BCD digits take the same +6 correction, so 15+15+1 yields 5 with carry.
    for (genvar i = 0; i < 4; i++) begin : g_digit
        logic [4:0] t;
        assign t = {1'b0, a_dig[i]} + {1'b0, b_dig[i]} + {4'b0, carry[i]};
        assign carry[i+1] = (t > 5'd9);
        assign s_dig[i]   = (t > 5'd9) ? (t[3:0] + 4'd6) : t[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 4'd0;
            s2 <= 4'd0;
            s3 <= 4'd0;
            s4 <= 4'd0;
            co <= 1'b0;
        end else begin
            s1 <= s_dig[0];
            s2 <= s_dig[1];
            s3 <= s_dig[2];
            s4 <= s_dig[3];
            co <= carry[4];
        end
    end

endmodule

// File: tb/tb_adder10_4.sv
// Scoreboard bench for adder10_4: stimulus pushes expected sums, a monitor pops them each cycle.
module tb_adder10_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] A1, A2, A3, A4, B1, B2, B3, B4;
    logic       cin;
    logic [3:0] s1, s2, s3, s4;
    logic       co;

    typedef struct {
        logic [15:0] s;
        logic        c;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    adder10_4 dut (
        .clk(clk), .rst_n(rst_n),
        .A1(A1), .A2(A2), .A3(A3), .A4(A4),
        .B1(B1), .B2(B2), .B3(B3), .B4(B4),
        .cin(cin),
        .s1(s1), .s2(s2), .s3(s3), .s4(s4),
        .co(co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    task automatic check_zero(input int id);
        checks++;
        if ({s4, s3, s2, s1} !== 16'h0000 || co !== 1'b0) begin
            failures++;
            $display("FAIL reset%0d: got s=%h co=%b, want s=0000 co=0", id, {s4, s3, s2, s1}, co);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic [15:0] es, input logic ec, input int id);
        exp_t e;
        {A4, A3, A2, A1} = a;
        {B4, B3, B2, B1} = b;
        cin = c;
        e.s = es;
        e.c = ec;
        e.id = id;
        sb.push_back(e);
    endtask

    task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic [15:0] es, input logic ec, input int id);
        @(negedge clk);
        drive(a, b, c, es, ec, id);
    endtask

    // Monitor: the result of the edge that captured a vector is visible just after that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({s4, s3, s2, s1} !== e.s || co !== e.c) begin
                    failures++;
                    $display("FAIL vec%0d: got s=%h co=%b, want s=%h co=%b",
                             e.id, {s4, s3, s2, s1}, co, e.s, e.c);
                end
            end
        end
    end

    initial begin
        int av, bv, cv, sum;
        rst_n = 1'b1;
        {A4, A3, A2, A1} = 16'h8765;
        {B4, B3, B2, B1} = 16'h4321;
        cin = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_zero(0);
        @(posedge clk);
        #2 check_zero(1);

        @(negedge clk);
        rst_n = 1'b1;
        drive(16'h1234, 16'h5678, 1'b1, 16'h6913, 1'b0, 1);
        apply(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 2);
        apply(16'h5555, 16'h4444, 1'b0, 16'h9999, 1'b0, 3);
        apply(16'h5555, 16'h4444, 1'b1, 16'h0000, 1'b1, 4);
        apply(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 5);
        apply(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 6);
        apply(16'hFFFF, 16'hFFFF, 1'b1, 16'h5555, 1'b1, 7);
        apply(16'h000F, 16'h0000, 1'b0, 16'h0015, 1'b0, 8);
        apply(16'h0909, 16'h0101, 1'b0, 16'h1010, 1'b0, 9);
        apply(16'h4999, 16'h0000, 1'b1, 16'h5000, 1'b0, 10);

        for (int i = 0; i < 24; i++) begin
            av  = int'($urandom_range(0, 9999));
            bv  = int'($urandom_range(0, 9999));
            cv  = int'($urandom_range(0, 1));
            sum = av + bv + cv;
            apply(to_bcd(av), to_bcd(bv), cv[0], to_bcd(sum % 10000), (sum >= 10000), 100 + i);
        end

        apply(16'h2468, 16'h1357, 1'b0, 16'h3825, 1'b0, 11);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero(2);
        @(negedge clk);
        rst_n = 1'b1;
        drive(16'h0042, 16'h0058, 1'b0, 16'h0100, 1'b0, 12);
        apply(16'h8000, 16'h2000, 1'b1, 16'h0001, 1'b1, 13);

        @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending results, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
